alu_issue_unit: RTL and testbench

//  Register-file front-end and sequencer for the combinational ALU (alu2020).

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_issue_unit_if.sv | 21 ++
 rtl/alu_regfile.sv | 52 +++++
 rtl/alu_issue_unit.sv | 133 +++++++++++++
 tb/tb_alu_issue_unit.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue unit and its register file.
package alu_pkg;

    // Opcode width, fixed by the downstream ALU
    localparam int OPW = 4;

    // Opcodes understood by the ALU; every other code raises hata
    localparam logic [OPW-1:0] OP_ADD = 4'h0;
    localparam logic [OPW-1:0] OP_SUB = 4'h1;
    localparam logic [OPW-1:0] OP_AND = 4'h2;
    localparam logic [OPW-1:0] OP_OR  = 4'h3;
    localparam logic [OPW-1:0] OP_XOR = 4'h4;
    localparam logic [OPW-1:0] OP_SLL = 4'h5;
    localparam logic [OPW-1:0] OP_SRL = 4'h6;
    localparam logic [OPW-1:0] OP_SRA = 4'h7;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } issue_state_t;

    // ALU condition flags, packed in {n,z,v,c} order
    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } nzvc_t;

endpackage

// File: rtl/alu_issue_unit_if.sv
// Command channel into the issue unit: valid/ready handshake plus register-to-register fields.
interface alu_issue_unit_if import alu_pkg::*; #(
    parameter int RW = 3
);
    logic           cmd_valid;
    logic           cmd_ready;
    logic [OPW-1:0] cmd_op;
    logic [RW-1:0]  cmd_rd;
    logic [RW-1:0]  cmd_rs1;
    logic [RW-1:0]  cmd_rs2;

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2,
        output cmd_ready
    );
endinterface

// File: rtl/alu_regfile.sv
// Register file: two operand read ports, one debug read port, one write port.
// Entry 0 is never written, so it reads as zero after reset.
module alu_regfile #(
    parameter  int XLEN = 32,
    parameter  int NREG = 8,
    localparam int RW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [RW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [RW-1:0]   raddr1,
    input  logic [RW-1:0]   raddr2,
    input  logic [RW-1:0]   dbg_addr,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    output logic [XLEN-1:0] dbg_data
);

    logic [XLEN-1:0] rf_reg [NREG];
    logic [NREG-1:0] wsel;

    // One-hot write select; the entry-0 select is tied low so r0 writes are dropped
    for (genvar gi = 0; gi < NREG; gi++) begin : g_wsel
        if (gi == 0) begin : g_zero
            assign wsel[gi] = 1'b0;
        end else begin : g_entry
            assign wsel[gi] = we && (waddr == RW'(gi));
        end
    end

    // Storage update: clear everything on reset, otherwise write the selected entry
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wsel[i]) begin
                    rf_reg[i] <= wdata;
                end
            end
        end
    end

    assign rdata1   = rf_reg[raddr1];
    assign rdata2   = rf_reg[raddr2];
    assign dbg_data = rf_reg[dbg_addr];

endmodule

// File: rtl/alu_issue_unit.sv
// Register-file front end and sequencer for the combinational ALU.
// Accepts a command, presents registered operands for one cycle, writes the
// result back, then pulses done. One command every three cycles at most.
module alu_issue_unit import alu_pkg::*; #(
    parameter  int XLEN = 32,
    parameter  int NREG = 8,
    localparam int RW   = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_valid,
    input  logic [RW-1:0]    ld_addr,
    input  logic [XLEN-1:0]  ld_data,
    alu_issue_unit_if.slave  cmd,
    output logic [XLEN-1:0]  alu_a,
    output logic [XLEN-1:0]  alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [XLEN-1:0]  alu_s,
    input  logic [3:0]       alu_nzvc,
    input  logic             alu_hata,
    output logic             done,
    output logic [XLEN-1:0]  result,
    output logic [3:0]       flags,
    output logic             err,
    input  logic [RW-1:0]    dbg_addr,
    output logic [XLEN-1:0]  dbg_data
);

    issue_state_t    state_reg;
    logic [XLEN-1:0] alu_a_reg;
    logic [XLEN-1:0] alu_b_reg;
    logic [OPW-1:0]  alu_op_reg;
    logic [RW-1:0]   rd_q_reg;
    logic [XLEN-1:0] result_reg;
    nzvc_t           flags_reg;
    logic            done_reg;
    logic            err_reg;

    logic            wr_en_next;
    logic [RW-1:0]   wr_addr_next;
    logic [XLEN-1:0] wr_data_next;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;

    // Loads take priority, so a command is only offered while idle with no load pending
    assign cmd.cmd_ready = (state_reg == IDLE) && !ld_valid;

    // Single write port shared by preloads (IDLE) and ALU writeback (EXEC, legal op only)
    always_comb begin
        wr_en_next   = 1'b0;
        wr_addr_next = ld_addr;
        wr_data_next = ld_data;
        if (!rst) begin
            if (state_reg == IDLE && ld_valid) begin
                wr_en_next = 1'b1;
            end else if (state_reg == EXEC && !alu_hata) begin
                wr_en_next   = 1'b1;
                wr_addr_next = rd_q_reg;
                wr_data_next = alu_s;
            end
        end
    end

    alu_regfile #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (wr_en_next),
        .waddr    (wr_addr_next),
        .wdata    (wr_data_next),
        .raddr1   (cmd.cmd_rs1),
        .raddr2   (cmd.cmd_rs2),
        .dbg_addr (dbg_addr),
        .rdata1   (rs1_data),
        .rdata2   (rs2_data),
        .dbg_data (dbg_data)
    );

    // Sequencer: IDLE accepts, EXEC samples the ALU, DONE raises the completion pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            alu_a_reg  <= '0;
            alu_b_reg  <= '0;
            alu_op_reg <= '0;
            rd_q_reg   <= '0;
            result_reg <= '0;
            flags_reg  <= '0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (!ld_valid && cmd.cmd_valid) begin
                        alu_a_reg  <= rs1_data;
                        alu_b_reg  <= rs2_data;
                        alu_op_reg <= cmd.cmd_op;
                        rd_q_reg   <= cmd.cmd_rd;
                        state_reg  <= EXEC;
                    end
                end
                EXEC: begin
                    result_reg <= alu_s;
                    if (alu_hata) begin
                        err_reg <= 1'b1;
                    end else begin
                        flags_reg <= nzvc_t'(alu_nzvc);
                    end
                    done_reg  <= 1'b1;
                    state_reg <= DONE;
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign alu_a  = alu_a_reg;
    assign alu_b  = alu_b_reg;
    assign alu_op = alu_op_reg;
    assign done   = done_reg;
    assign result = result_reg;
    assign flags  = flags_reg;
    assign err    = err_reg;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed testbench for alu_issue_unit with a behavioural ALU in the loop.
// A driver pushes the hand-computed outcome of each command into a queue; a
// monitor pops and compares whenever done is seen.
module tb_alu_issue_unit;
    import alu_pkg::*;

    localparam int XLEN = 32;
    localparam int NREG = 8;
    localparam int RW   = 3;
    localparam logic [XLEN-1:0] ILLEGAL_S = 32'hBADC_0DE0;
    localparam logic [OPW-1:0]  OP_BAD    = 4'hF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic            rst;
    logic            ld_valid;
    logic [RW-1:0]   ld_addr;
    logic [XLEN-1:0] ld_data;
    logic [XLEN-1:0] alu_a, alu_b, alu_s;
    logic [OPW-1:0]  alu_op;
    logic [3:0]      alu_nzvc;
    logic            alu_hata;
    logic            done;
    logic [XLEN-1:0] result;
    logic [3:0]      flags;
    logic            err;
    logic [RW-1:0]   dbg_addr;
    logic [XLEN-1:0] dbg_data;

    alu_issue_unit_if #(.RW(RW)) cmd_if();

    alu_issue_unit #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ld_valid (ld_valid),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .cmd      (cmd_if),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_op   (alu_op),
        .alu_s    (alu_s),
        .alu_nzvc (alu_nzvc),
        .alu_hata (alu_hata),
        .done     (done),
        .result   (result),
        .flags    (flags),
        .err      (err),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // Behavioural ALU: SUB carry means no borrow; unknown opcodes raise hata
    logic [XLEN:0] alu_wide;
    logic          alu_v, alu_c;
    always_comb begin
        alu_wide = '0;
        alu_s    = '0;
        alu_v    = 1'b0;
        alu_c    = 1'b0;
        alu_hata = 1'b0;
        case (alu_op)
            OP_ADD: begin
                alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
                alu_s    = alu_wide[XLEN-1:0];
                alu_c    = alu_wide[XLEN];
                alu_v    = (alu_a[XLEN-1] == alu_b[XLEN-1]) && (alu_s[XLEN-1] != alu_a[XLEN-1]);
            end
            OP_SUB: begin
                alu_s = alu_a - alu_b;
                alu_c = (alu_a >= alu_b);
                alu_v = (alu_a[XLEN-1] != alu_b[XLEN-1]) && (alu_s[XLEN-1] != alu_a[XLEN-1]);
            end
            OP_AND: alu_s = alu_a & alu_b;
            OP_OR:  alu_s = alu_a | alu_b;
            OP_XOR: alu_s = alu_a ^ alu_b;
            OP_SLL: alu_s = alu_a << alu_b[4:0];
            OP_SRL: alu_s = alu_a >> alu_b[4:0];
            OP_SRA: alu_s = $signed(alu_a) >>> alu_b[4:0];
            default: begin
                alu_s    = ILLEGAL_S;
                alu_hata = 1'b1;
            end
        endcase
        alu_nzvc = {alu_s[XLEN-1], (alu_s == '0), alu_v, alu_c};
    end

    typedef struct {
        logic [XLEN-1:0] result;
        logic [3:0]      flags;
        logic            err;
        logic [XLEN-1:0] rdval;
        int              acc_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass   = 0;
    int   n_total  = 0;
    int   last_acc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    // Monitor: every done cycle must match the oldest outstanding expectation
    initial begin
        forever begin : mon_body
            exp_t e;
            @(negedge clk);
            if (done) begin
                if (sb_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_done: got done=1 with nothing outstanding, required done=0");
                end else begin
                    e = sb_q.pop_front();
                    $display("done @%0d: result=%h flags=%b err=%b rf[rd]=%h", cyc, result, flags, err, dbg_data);
                    chk("done_result",  result, e.result);
                    chk("done_flags",   32'(flags), 32'(e.flags));
                    chk("done_err",     32'(err), 32'(e.err));
                    chk("done_rf_rd",   dbg_data, e.rdval);
                    chk("done_latency", 32'(cyc - e.acc_cyc), 32'd2);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish, required finish within 100000 time units");
        $fatal(1, "timeout");
    end

    task automatic ld(input logic [RW-1:0] a, input logic [XLEN-1:0] d);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
    endtask

    // Present a command, wait (bounded) for the accept, record the expectation.
    // Returns one time step after the accept edge, i.e. in the EXEC cycle.
    task automatic issue(input logic [OPW-1:0] op, input logic [RW-1:0] rd, input logic [RW-1:0] rs1,
                         input logic [RW-1:0] rs2, input logic [XLEN-1:0] er, input logic [3:0] ef,
                         input logic ee, input logic [XLEN-1:0] ev, input bit expect_done);
        exp_t e;
        bit   ok;
        ok = 1'b0;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_rd    = rd;
        cmd_if.cmd_rs1   = rs1;
        cmd_if.cmd_rs2   = rs2;
        cmd_if.cmd_valid = 1'b1;
        dbg_addr         = rd;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (cmd_if.cmd_ready) begin
                ok = 1'b1;
                last_acc = cyc;
                $display("issue @%0d: op=%h rd=%0d rs1=%0d rs2=%0d", cyc, op, rd, rs1, rs2);
                if (expect_done) begin
                    e.result  = er;
                    e.flags   = ef;
                    e.err     = ee;
                    e.rdval   = ev;
                    e.acc_cyc = cyc;
                    sb_q.push_back(e);
                end
            end
        end
        if (!ok) begin
            n_total++;
            $display("FAIL accept_timeout: got cmd_ready=0 for 20 cycles, required an accept");
        end
        @(posedge clk);
        #1;
    endtask

    // Drop cmd_valid and let the current command run through DONE back to IDLE
    task automatic finish_cmd();
        cmd_if.cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    int ld_cyc;
    int prev_acc;

    initial begin
        rst              = 1'b1;
        ld_valid         = 1'b0;
        ld_addr          = '0;
        ld_data          = '0;
        dbg_addr         = '0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = '0;
        cmd_if.cmd_rd    = '0;
        cmd_if.cmd_rs1   = '0;
        cmd_if.cmd_rs2   = '0;

        // 1. reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_cmd_ready", 32'(cmd_if.cmd_ready), 32'd1);
        chk("reset_done",      32'(done), 32'd0);
        chk("reset_flags",     32'(flags), 32'd0);
        chk("reset_err",       32'(err), 32'd0);
        chk("reset_result",    result, 32'd0);
        chk("reset_alu_op",    32'(alu_op), 32'd0);
        for (int i = 0; i < NREG; i++) begin
            dbg_addr = RW'(i);
            #1;
            chk($sformatf("reset_rf%0d", i), dbg_data, 32'd0);
        end
        @(posedge clk);
        #1;

        // 2. ADD with signed overflow
        ld(3'd1, 32'h7FFF_FFFF);
        ld(3'd2, 32'h0000_0001);
        issue(OP_ADD, 3'd3, 3'd1, 3'd1 + 3'd1, 32'h8000_0000, 4'b1010, 1'b0, 32'h8000_0000, 1'b1);
        finish_cmd();

        // 3. r0 ignores loads and writeback; SUB equal operands gives z and no-borrow
        ld(3'd0, 32'hDEAD_BEEF);
        dbg_addr = 3'd0;
        #1;
        chk("ld_r0_dropped", dbg_data, 32'd0);
        issue(OP_SUB, 3'd0, 3'd1, 3'd1, 32'h0000_0000, 4'b0101, 1'b0, 32'h0000_0000, 1'b1);
        finish_cmd();

        // 4. illegal opcode: no writeback, flags kept, err set and sticky
        issue(OP_BAD, 3'd3, 3'd1, 3'd2, ILLEGAL_S, 4'b0101, 1'b1, 32'h8000_0000, 1'b1);
        finish_cmd();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("err_sticky",  32'(err), 32'd1);
        chk("result_held", result, ILLEGAL_S);
        @(posedge clk);
        #1;

        // 5. burst with cmd_valid held; load in the first accept slot wins
        cmd_if.cmd_op    = OP_AND;
        cmd_if.cmd_rd    = 3'd6;
        cmd_if.cmd_rs1   = 3'd5;
        cmd_if.cmd_rs2   = 3'd1;
        cmd_if.cmd_valid = 1'b1;
        dbg_addr         = 3'd6;
        ld_valid         = 1'b1;
        ld_addr          = 3'd5;
        ld_data          = 32'h0000_00F0;
        @(negedge clk);
        chk("ld_blocks_ready", 32'(cmd_if.cmd_ready), 32'd0);
        ld_cyc = cyc;
        @(posedge clk);
        #1 ld_valid = 1'b0;
        issue(OP_AND, 3'd6, 3'd5, 3'd1, 32'h0000_00F0, 4'b0000, 1'b1, 32'h0000_00F0, 1'b1);
        chk("accept_after_ld", 32'(last_acc - ld_cyc), 32'd1);
        prev_acc = last_acc;
        repeat (2) @(posedge clk);
        #1;
        issue(OP_XOR, 3'd7, 3'd6, 3'd3, 32'h8000_00F0, 4'b1000, 1'b1, 32'h8000_00F0, 1'b1);
        chk("accept_spacing_2", 32'(last_acc - prev_acc), 32'd3);
        prev_acc = last_acc;
        repeat (2) @(posedge clk);
        #1;
        issue(OP_SRA, 3'd4, 3'd7, 3'd2, 32'hC000_0078, 4'b1000, 1'b1, 32'hC000_0078, 1'b1);
        chk("accept_spacing_3", 32'(last_acc - prev_acc), 32'd3);
        finish_cmd();

        // 6. reset while in EXEC: no done, back to IDLE and ready
        issue(OP_ADD, 3'd4, 3'd1, 3'd2, 32'h0, 4'b0, 1'b0, 32'h0, 1'b0);
        cmd_if.cmd_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_exec_ready", 32'(cmd_if.cmd_ready), 32'd1);
        chk("rst_exec_done",  32'(done), 32'd0);
        chk("rst_exec_rf4",   dbg_data, 32'd0);
        chk("rst_exec_err",   32'(err), 32'd0);
        chk("rst_exec_flags", 32'(flags), 32'd0);
        repeat (5) @(posedge clk);
        @(negedge clk);

        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
